// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces the first
// single-row press it finds, and reports the key code plus a 7-segment glyph.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 250000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [6:0] HEX0
);

   localparam int CMAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
   localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [1:0]      col_idx, col_idx_nxt, row_idx, low_idx;
   logic [3:0]      row_m, row_s;
   logic            one_low, key_up, advance, latch, accept, held_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // rows are asynchronous to clk; nothing looks at them before row_s
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_m <= 4'hF;
         row_s <= 4'hF;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   always_comb begin
      one_low = $onehot(~row_s);
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!row_s[i]) low_idx = 2'(i);
   end

   assign key_up = row_s[row_idx];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= SCAN;
         cnt     <= '0;
         col_idx <= 2'd0;
         row_idx <= 2'd0;
      end else begin
         state   <= state_nxt;
         col_idx <= col_idx_nxt;
         if (latch) row_idx <= low_idx;
         // HELD has no timeout, so the counter parks there instead of wrapping
         if (state_nxt != state || advance) cnt <= '0;
         else if (state != HELD)            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SCAN:      if (cnt == SCAN_LAST && one_low) state_nxt = DEB_PRESS;
         DEB_PRESS: if (key_up)                state_nxt = SCAN;
                    else if (cnt == DEB_LAST)  state_nxt = HELD;
         HELD:      if (key_up)                state_nxt = DEB_REL;
         DEB_REL:   if (!key_up)               state_nxt = HELD;
                    else if (cnt == DEB_LAST)  state_nxt = SCAN;
         default:   state_nxt = SCAN;
      endcase
   end

   always_comb begin
      advance = 1'b0;
      latch   = 1'b0;
      accept  = 1'b0;
      case (state)
         SCAN:      if (cnt == SCAN_LAST) begin
                       if (one_low) latch   = 1'b1;
                       else         advance = 1'b1;
                    end
         DEB_PRESS: if (key_up)               advance = 1'b1;
                    else if (cnt == DEB_LAST) accept  = 1'b1;
         DEB_REL:   if (key_up && cnt == DEB_LAST) advance = 1'b1;
         default:   ;
      endcase
      col_idx_nxt = advance ? col_idx + 2'd1 : col_idx;
      held_nxt    = (state_nxt == HELD) || (state_nxt == DEB_REL);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col       <= 4'b1110;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         HEX0      <= 7'h7F;
      end else begin
         col       <= ~(4'b0001 << col_idx_nxt);
         key_valid <= accept;
         key_held  <= held_nxt;
         if (accept) begin
            key_code <= {col_idx, row_idx};
            HEX0     <= hex7({col_idx, row_idx});
         end
      end
   end

endmodule
